// File: rtl/bj_pkg.sv
// rtl/bj_pkg.sv - shared types and constants for the branch/jump execute stage
package bj_pkg;

    localparam int BJ_JUMP = 4;
    localparam int BJ_BNE  = 3;
    localparam int BJ_BEQ  = 2;
    localparam int BJ_BGE  = 1;
    localparam int BJ_BLT  = 0;

    localparam int LINK_OFS_DEF = 4;

    typedef struct packed {
        logic jump;
        logic bne;
        logic beq;
        logic bge;
        logic blt;
    } bj_op_t;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } bj_state_t;

    // Reduce a possibly multi-hot decode vector to its highest-priority bit.
    function automatic bj_op_t bj_prio(input logic [4:0] raw);
        logic [4:0] sel;
        sel = '0;
        if (raw[BJ_JUMP])     sel[BJ_JUMP] = 1'b1;
        else if (raw[BJ_BNE]) sel[BJ_BNE]  = 1'b1;
        else if (raw[BJ_BEQ]) sel[BJ_BEQ]  = 1'b1;
        else if (raw[BJ_BGE]) sel[BJ_BGE]  = 1'b1;
        else if (raw[BJ_BLT]) sel[BJ_BLT]  = 1'b1;
        return bj_op_t'(sel);
    endfunction

endpackage

// File: rtl/bj_resolve.sv
// rtl/bj_resolve.sv - combinational branch direction, target and link computation
module bj_resolve
    import bj_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LINK_OFS = LINK_OFS_DEF
) (
    input  bj_op_t            op,
    input  logic              uns,
    input  logic              jalr,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   imm,
    output logic              taken,
    output logic [XLEN-1:0]   target,
    output logic [XLEN-1:0]   link
);

    logic            eq;
    logic            lt;
    logic [XLEN-1:0] reg_sum;

    assign eq      = (rs1 == rs2);
    assign lt      = uns ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
    assign reg_sum = rs1 + imm;

    assign taken = op.jump | (op.bne & ~eq) | (op.beq & eq)
                 | (op.bge & ~lt) | (op.blt & lt);

    // JALR targets are halfword aligned by clearing bit 0 of the sum.
    assign target = (op.jump & jalr) ? {reg_sum[XLEN-1:1], 1'b0} : (pc + imm);
    assign link   = pc + XLEN'(LINK_OFS);

endmodule

// File: rtl/bj_execute.sv
// rtl/bj_execute.sv - branch/jump execute stage with link writeback and fetch redirect
module bj_execute
    import bj_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LINK_OFS = LINK_OFS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kill,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_bj_op_en,
    input  logic              in_unsigned,
    input  logic              in_jalr,
    input  logic              in_pred_taken,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_imm,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [XLEN-1:0]   redir_pc
);

    bj_state_t       state;
    bj_op_t          op;
    logic            wb_pend;
    logic            redir_pend;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            hold_free;
    logic            accept;
    logic            new_wb;
    logic            new_redir;
    logic            wb_keep;
    logic            redir_keep;

    assign op = bj_prio(in_bj_op_en);

    bj_resolve #(
        .XLEN     (XLEN),
        .LINK_OFS (LINK_OFS)
    ) u_resolve (
        .op     (op),
        .uns    (in_unsigned),
        .jalr   (in_jalr),
        .pc     (in_pc),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .taken  (taken),
        .target (target),
        .link   (link)
    );

    assign wb_valid    = wb_pend;
    assign redir_valid = redir_pend;

    assign hold_free = (~wb_pend | wb_ready) & (~redir_pend | redir_ready);
    assign in_ready  = rst_n & ~kill & ((state == ST_IDLE) | ((state == ST_HOLD) & hold_free));
    assign accept    = in_valid & in_ready;

    // An empty op vector retires silently, even if fetch predicted taken.
    assign new_wb     = op.jump;
    assign new_redir  = (|in_bj_op_en) & ((taken != in_pred_taken) | (op.jump & in_jalr));
    assign wb_keep    = wb_pend & ~wb_ready;
    assign redir_keep = redir_pend & ~redir_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wb_pend    <= 1'b0;
            redir_pend <= 1'b0;
            wb_data    <= '0;
            redir_pc   <= '0;
        end else if (kill) begin
            state      <= ST_IDLE;
            wb_pend    <= 1'b0;
            redir_pend <= 1'b0;
        end else if (accept) begin
            wb_pend    <= new_wb;
            redir_pend <= new_redir;
            wb_data    <= link;
            redir_pc   <= taken ? target : link;
            state      <= (new_wb | new_redir) ? ST_HOLD : ST_IDLE;
        end else begin
            wb_pend    <= wb_keep;
            redir_pend <= redir_keep;
            state      <= (wb_keep | redir_keep) ? ST_HOLD : ST_IDLE;
        end
    end

    a_onehot_op: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && in_ready) |-> $onehot0(in_bj_op_en));

endmodule

// File: tb/tb_bj_execute.sv
// tb/tb_bj_execute.sv - randomized scoreboard bench for bj_execute
module tb_bj_execute;

    logic        clk = 1'b0;
    logic        rst_n, kill, in_valid, in_ready;
    logic [4:0]  in_bj_op_en;
    logic        in_unsigned, in_jalr, in_pred_taken;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic        wb_valid, wb_ready, redir_valid, redir_ready;
    logic [31:0] wb_data, redir_pc;

    always #5 clk = ~clk;

    bj_execute #(.XLEN(32), .LINK_OFS(4)) dut (
        .clk(clk), .rst_n(rst_n), .kill(kill),
        .in_valid(in_valid), .in_ready(in_ready), .in_bj_op_en(in_bj_op_en),
        .in_unsigned(in_unsigned), .in_jalr(in_jalr), .in_pred_taken(in_pred_taken),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] wb_q[$];
    logic [31:0] rd_q[$];
    bit          mon_en = 0;
    bit          rand_rdy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: branch semantics from plain integer arithmetic.
    task automatic model(input logic [4:0] op, input logic uns, input logic jalr, input logic pred,
                         input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, output logic wbp, output logic [31:0] wbd,
                         output logic rdp, output logic [31:0] rdpc);
        longint va, vb;
        bit     taken;
        logic [31:0] tgt;
        va = longint'(a);
        vb = longint'(b);
        if (!uns && a[31]) va = va - 64'h1_0000_0000;
        if (!uns && b[31]) vb = vb - 64'h1_0000_0000;
        if (op[4])      taken = 1;
        else if (op[3]) taken = (a != b);
        else if (op[2]) taken = (a == b);
        else if (op[1]) taken = !(va < vb);
        else if (op[0]) taken = (va < vb);
        else            taken = 0;
        if (op[4] && jalr) begin
            tgt = a + imm;
            tgt[0] = 1'b0;
        end else begin
            tgt = pc + imm;
        end
        wbp  = op[4];
        wbd  = pc + 32'd4;
        rdp  = (op != 5'd0) && ((taken != pred) || (op[4] && jalr));
        rdpc = taken ? tgt : pc + 32'd4;
    endtask

    logic        s_acc = 0, s_kill = 0, s_wbp, s_rdp;
    logic [31:0] s_wbd, s_rdpc;

    always @(negedge clk) begin
        s_acc  = in_valid && in_ready;
        s_kill = kill;
        model(in_bj_op_en, in_unsigned, in_jalr, in_pred_taken, in_pc, in_rs1, in_rs2, in_imm,
              s_wbp, s_wbd, s_rdp, s_rdpc);
    end

    always @(posedge clk) begin
        if (!rst_n || s_kill) begin
            wb_q.delete();
            rd_q.delete();
        end else if (s_acc) begin
            if (s_wbp) wb_q.push_back(s_wbd);
            if (s_rdp) rd_q.push_back(s_rdpc);
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("in_ready", in_ready,
                  !kill && (wb_q.size() == 0 || wb_ready) && (rd_q.size() == 0 || redir_ready));
            check("wb_valid", wb_valid, wb_q.size() != 0);
            if (wb_valid && wb_q.size() != 0) begin
                check("wb_data", wb_data, wb_q[0]);
                if (wb_ready) void'(wb_q.pop_front());
            end
            check("redir_valid", redir_valid, rd_q.size() != 0);
            if (redir_valid && rd_q.size() != 0) begin
                check("redir_pc", redir_pc, rd_q[0]);
                if (redir_ready) void'(rd_q.pop_front());
            end
        end
    end

    task automatic rand_ready();
        wb_ready    = ($urandom % 3) != 0;
        redir_ready = ($urandom % 3) != 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_rdy) rand_ready();
        end
    endtask

    task automatic drive_op(input logic [4:0] op, input logic uns, input logic jalr, input logic pred,
                            input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, output int stalls);
        bit ok;
        in_bj_op_en = op; in_unsigned = uns; in_jalr = jalr; in_pred_taken = pred;
        in_pc = pc; in_rs1 = a; in_rs2 = b; in_imm = imm;
        in_valid = 1;
        stalls = 0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (!ok) stalls++;
            if (rand_rdy) rand_ready();
        end
        in_valid = 0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", stalls);
        end
    endtask

    task automatic do_kill(input bit v);
        kill = 1;
        in_valid = v;
        @(posedge clk);
        #1;
        kill = 0;
        in_valid = 0;
        if (rand_rdy) rand_ready();
    endtask

    int          st, total;
    logic [4:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        rst_n = 0; kill = 0; in_valid = 0; in_bj_op_en = 0; in_unsigned = 0; in_jalr = 0;
        in_pred_taken = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
        wb_ready = 1; redir_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_redir_valid", redir_valid, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("rst_wb_data", wb_data, 0);
        check("rst_redir_pc", redir_pc, 0);
        check("idle_in_ready", in_ready, 1);
        idle(1);
        mon_en = 1;

        drive_op(5'b00100, 0, 0, 0, 32'h100, 32'd5, 32'd5, 32'h20, st);
        @(negedge clk);
        check("beq_redir_valid", redir_valid, 1);
        check("beq_redir_pc", redir_pc, 32'h120);
        check("beq_wb_valid", wb_valid, 0);
        idle(2);

        drive_op(5'b00001, 0, 0, 1, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, st);
        @(negedge clk);
        check("blts_redir_valid", redir_valid, 0);
        check("blts_wb_valid", wb_valid, 0);
        check("blts_in_ready", in_ready, 1);
        idle(1);
        drive_op(5'b00001, 1, 0, 1, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, st);
        @(negedge clk);
        check("bltu_redir_valid", redir_valid, 1);
        check("bltu_redir_pc", redir_pc, 32'h304);
        idle(2);

        wb_ready = 0; redir_ready = 1;
        drive_op(5'b10000, 0, 1, 1, 32'h200, 32'h1003, 32'd0, 32'h10, st);
        @(negedge clk);
        check("jalr_redir_pc", redir_pc, 32'h1012);
        check("jalr_wb_data", wb_data, 32'h204);
        check("jalr_in_ready", in_ready, 0);
        idle(3);
        @(negedge clk);
        check("jalr_redir_gone", redir_valid, 0);
        check("jalr_wb_held", wb_valid, 1);
        check("jalr_wb_stable", wb_data, 32'h204);
        idle(1);
        wb_ready = 1;
        idle(2);

        total = 0;
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? ra : $urandom;
            drive_op(5'b01000, 0, 0, i[1], 32'h1000 + 32'(i * 4), ra, rb, $urandom, st);
            total += st;
        end
        check("b2b_stalls", total, 0);
        idle(2);

        wb_ready = 0; redir_ready = 0;
        drive_op(5'b10000, 0, 0, 0, 32'h500, 32'd0, 32'd0, 32'h80, st);
        idle(1);
        do_kill(1);
        @(negedge clk);
        check("kill_wb_valid", wb_valid, 0);
        check("kill_redir_valid", redir_valid, 0);
        check("kill_in_ready", in_ready, 1);
        idle(1);

        drive_op(5'b10000, 0, 0, 0, 32'h400, 32'd0, 32'd0, 32'h40, st);
        #2;
        rst_n = 0;
        #1;
        check("arst_wb_valid", wb_valid, 0);
        check("arst_redir_valid", redir_valid, 0);
        check("arst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1;
        wb_ready = 1; redir_ready = 1;
        idle(1);

        drive_op(5'b00000, 0, 0, 1, 32'h600, 32'd1, 32'd2, 32'h8, st);
        @(negedge clk);
        check("none_redir_valid", redir_valid, 0);
        check("none_wb_valid", wb_valid, 0);
        idle(1);

        rand_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom % 10)
                0:       do_kill($urandom % 2);
                1, 2:    idle(1 + $urandom % 2);
                default: ;
            endcase
            rop = ($urandom % 6 == 0) ? 5'd0 : (5'd1 << ($urandom % 5));
            ra  = ($urandom % 5 == 0) ? 32'h8000_0000 : $urandom;
            rb  = ($urandom % 4 == 0) ? ra : (($urandom % 5 == 0) ? 32'h7FFF_FFFF : $urandom);
            drive_op(rop, $urandom % 2, $urandom % 2, $urandom % 2, $urandom & 32'hFFFF_FFFC,
                     ra, rb, $urandom, st);
        end

        rand_rdy = 0;
        wb_ready = 1; redir_ready = 1;
        idle(3);
        @(negedge clk);
        check("drain_wb_pending", wb_q.size(), 0);
        check("drain_redir_pending", rd_q.size(), 0);
        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bj_execute.md
Name: bj_execute

Overview:
Branch/jump execute stage sitting directly downstream of the stage-2 branch/jump op decoder. It consumes the 5-bit one-hot BjOpEn vector {Jump,Bne,Beq,Bge,Blt} plus operands, and resolves branch direction and target. It produces the link-register writeback for JAL/JALR and a fetch redirect on misprediction. Each output is held under its own valid/ready handshake until consumed.

Parameters:
XLEN, 32, operand and PC width
LINK_OFS, 4, byte offset from PC to the link / fall-through address

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
kill  in  1  pipeline flush from a later stage; drops all held state
in_valid  in  1  op present
in_ready  out  1  stage can accept op
in_bj_op_en  in  5  {Jump,Bne,Beq,Bge,Blt} from decode
in_unsigned  in  1  funct3[1]: unsigned compare for Bge/Blt
in_jalr  in  1  jump is JALR (register-relative target)
in_pred_taken  in  1  fetch predicted taken
in_pc  in  XLEN  instruction PC
in_rs1  in  XLEN  source 1
in_rs2  in  XLEN  source 2
in_imm  in  XLEN  sign-extended immediate
wb_valid  out  1  link result pending
wb_ready  in  1  writeback accepts
wb_data  out  XLEN  in_pc + LINK_OFS
redir_valid  out  1  redirect pending
redir_ready  in  1  fetch accepts redirect
redir_pc  out  XLEN  corrected fetch PC

Behaviour:
- Reset is asynchronous and active-low: one clock (clk), asynchronous active-low reset rst_n. On reset: state=IDLE, wb_valid=0, redir_valid=0, wb_data=0, redir_pc=0. in_ready is 0 while rst_n=0.
- States: IDLE and HOLD. HOLD is entered when an accepted op produces at least one pending output.
- Flags wb_pend and redir_pend drive wb_valid and redir_valid directly from registers.
- Accept: the op is accepted when in_valid & in_ready. Results are registered, so outputs are visible the cycle after acceptance (latency 1).
- in_ready = !kill & (IDLE | (HOLD & (!wb_pend | wb_ready) & (!redir_pend | redir_ready))). This gives 1 op/cycle throughput when consumers are always ready.
- Resolution:
  - Eq = rs1==rs2.
  - Lt = signed or unsigned rs1<rs2, selected by in_unsigned.
  - taken = Jump | (Bne&!Eq) | (Beq&Eq) | (Bge&!Lt) | (Blt&Lt).
- Target:
  - JALR: (rs1+imm) with bit0 cleared.
  - Otherwise: pc+imm.
  - All adds are modulo 2^XLEN and wrap silently.
- Pending outputs:
  - wb_pend set iff Jump.
  - redir_pend set iff taken != in_pred_taken, or (Jump & in_jalr).
  - redir_pc = taken ? target : pc+LINK_OFS.
- in_bj_op_en == 0: the op is accepted and retires with no outputs; state stays or returns to IDLE.
- Multi-hot in_bj_op_en: priority Jump>Bne>Beq>Bge>Blt; the simulation assertion fires.
- Each flag clears on its own handshake (valid&ready). HOLD→IDLE when both flags are clear and no new op is accepted that cycle.
- The two outputs may complete in the same or different cycles, in either order. Held outputs and data are stable while valid & !ready.
- kill: at the next edge, clear both flags and go to IDLE. Outputs being handshaken in the kill cycle still count as transferred. No op is accepted in a kill cycle.
- Reset mid-HOLD: outputs drop immediately (asynchronous).

Decomposition:
- Shared package (bj_pkg):
  - Typedef bj_op_t: 5-bit packed struct {jump,bne,beq,bge,blt}, ordered identically to decode.
  - Index constants for each bit.
  - LINK_OFS default.
- Sub-module bj_resolve: combinational compare/target unit (taken, target, link); bj_execute instantiates it and adds the state machine and registers.

Test Plan:
- Beq, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 → next cycle redir_valid=1, redir_pc=0x120, wb_valid=0; redir_ready=1 → IDLE.
- Blt signed, rs1=0xFFFFFFFF, rs2=1, pred_taken=1 → no outputs, in_ready stays 1. Same operands with in_unsigned=1 → redir_pc=pc+4.
- JALR, rs1=0x1003, imm=0x10, pc=0x200 → redir_pc=0x1012, wb_data=0x204. Hold wb_ready=0 for 3 cycles with redir_ready=1 → redirect leaves first, wb_data stays stable, in_ready=0 until the wb handshake.
- Back-to-back Bne ops on consecutive cycles with ready consumers → one result per cycle, in_ready never drops.
- kill asserted while HOLD with both flags pending → next cycle wb_valid=redir_valid=0, state IDLE; in_valid in the kill cycle is not accepted.
- rst_n pulsed low mid-HOLD → redir_valid, wb_valid and in_ready fall immediately without a clock edge. in_bj_op_en=0 → accepted with no outputs.
